// File: rtl/sim_angle_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sim_angle_sched
// Description : Round-robin angle-target scheduler sharing one wrap-aware
//               sector comparator. Optional macro SIM_SCHED_REF_EN enables
//               the unshifted reference comparison driving target_ref.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_angle_sched #(
   parameter int NTGT = 4
) (
   input  logic                    clk,
   input  logic                    resset,
   input  logic [11:0]             bear,
   input  logic                    run,
   input  logic                    cfg_we,
   input  logic [$clog2(NTGT)-1:0] cfg_addr,
   input  logic [11:0]             cfg_start,
   input  logic [11:0]             cfg_end,
   input  logic [3:0]              cfg_mode,
   output logic                    target_angle,
   output logic [$clog2(NTGT)-1:0] target_id,
   output logic                    target_ref,
   output logic                    rev_pulse
);
   localparam int              c_PW   = $clog2(NTGT);
   localparam logic [c_PW-1:0] c_LAST = c_PW'(NTGT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   state_t r_state, w_next;

   logic [11:0]      r_bear_q;
   logic [1:0]       r_bear_p;
   logic [c_PW-1:0]  r_ptr;
   logic             w_scan, w_upd, w_clr;

   logic [NTGT*12-1:0] w_start_flat, w_end_flat, w_off_flat;
   logic [NTGT-1:0]    w_valid_vec, w_hit_vec;
   logic [11:0]        w_sel_start, w_sel_end, w_sel_off, w_vstart, w_vend;
   logic               w_sel_valid, w_hit_mov;
   logic [c_PW-1:0]    w_id;

   function automatic logic f_in_sector(input logic [11:0] s, input logic [11:0] e,
                                        input logic [11:0] b);
      if (e > s)      return (b > s) && (b < e);
      else if (e < s) return (b > s) || (b < e);
      else            return 1'b0;
   endfunction

   always_ff @(posedge clk or negedge resset) begin
      if (!resset) begin
         r_bear_q  <= 12'd0;
         r_bear_p  <= 2'd0;
         rev_pulse <= 1'b0;
         r_state   <= S_IDLE;
      end else begin
         r_bear_q  <= bear;
         r_bear_p  <= r_bear_q[11:10];
         rev_pulse <= (r_bear_p == 2'b11) && (r_bear_q[11:10] == 2'b00);
         r_state   <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_next = S_SCAN;
         S_SCAN:   if (!run) w_next = S_IDLE;
                   else if (rev_pulse) w_next = S_UPDATE;
         S_UPDATE: w_next = run ? S_SCAN : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign w_scan = (r_state == S_SCAN) && run;
   assign w_upd  = (r_state == S_UPDATE);
   // Clearing on !run as well makes outputs drop one cycle after the IDLE entry.
   assign w_clr  = (r_state == S_IDLE) || !run;

   always_ff @(posedge clk or negedge resset) begin
      if (!resset)     r_ptr <= '0;
      else if (w_clr)  r_ptr <= '0;
      else if (w_scan) r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
   end

   // The single shared comparator works on whichever slot the pointer selects.
   assign w_sel_start = w_start_flat[r_ptr*12 +: 12];
   assign w_sel_end   = w_end_flat[r_ptr*12 +: 12];
   assign w_sel_off   = w_off_flat[r_ptr*12 +: 12];
   assign w_sel_valid = w_valid_vec[r_ptr];
   assign w_vstart    = w_sel_start + w_sel_off;
   assign w_vend      = w_sel_end + w_sel_off;
   assign w_hit_mov   = w_sel_valid && f_in_sector(w_vstart, w_vend, r_bear_q);

`ifdef SIM_SCHED_REF_EN
   logic [NTGT-1:0] w_ref_vec;
   logic            w_hit_ref;
   assign w_hit_ref = w_sel_valid && f_in_sector(w_sel_start, w_sel_end, r_bear_q);
`endif

   for (genvar gi = 0; gi < NTGT; gi++) begin : g_slot
      logic [11:0] r_start, r_end, r_off;
      logic [3:0]  r_mode;
      logic [2:0]  r_div;
      logic        r_hit;
      logic        w_wr, w_step, w_mine;

      assign w_wr   = cfg_we && (cfg_addr == c_PW'(gi));
      assign w_step = w_upd && r_mode[3] && r_mode[1];
      assign w_mine = w_scan && (r_ptr == c_PW'(gi));

      always_ff @(posedge clk or negedge resset) begin
         if (!resset) begin
            r_start <= 12'd0;
            r_end   <= 12'd0;
            r_mode  <= 4'd0;
            r_off   <= 12'd0;
            r_div   <= 3'd0;
         end else if (w_wr) begin
            r_start <= cfg_start;
            r_end   <= cfg_end;
            r_mode  <= cfg_mode;
            r_off   <= 12'd0;
            r_div   <= 3'd0;
         end else if (w_step) begin
            if (r_div == (r_mode[2] ? 3'd7 : 3'd1)) begin
               r_div <= 3'd0;
               r_off <= r_mode[0] ? r_off + 12'd1 : r_off - 12'd1;
            end else begin
               r_div <= r_div + 3'd1;
            end
         end
      end

      always_ff @(posedge clk or negedge resset) begin
         if (!resset)     r_hit <= 1'b0;
         else if (w_clr)  r_hit <= 1'b0;
         else if (w_mine) r_hit <= w_hit_mov;
      end

      assign w_start_flat[gi*12 +: 12] = r_start;
      assign w_end_flat[gi*12 +: 12]   = r_end;
      assign w_off_flat[gi*12 +: 12]   = r_off;
      assign w_valid_vec[gi]           = r_mode[3];
      assign w_hit_vec[gi]             = r_hit;

`ifdef SIM_SCHED_REF_EN
      logic r_ref;
      always_ff @(posedge clk or negedge resset) begin
         if (!resset)     r_ref <= 1'b0;
         else if (w_clr)  r_ref <= 1'b0;
         else if (w_mine) r_ref <= w_hit_ref;
      end
      assign w_ref_vec[gi] = r_ref;
`endif
   end

   always_comb begin
      w_id = '0;
      for (int i = NTGT - 1; i >= 0; i--) begin
         if (w_hit_vec[i]) w_id = c_PW'(i);
      end
   end

   always_ff @(posedge clk or negedge resset) begin
      if (!resset) begin
         target_angle <= 1'b0;
         target_id    <= '0;
      end else begin
         target_angle <= |w_hit_vec;
         target_id    <= w_id;
      end
   end

`ifdef SIM_SCHED_REF_EN
   always_ff @(posedge clk or negedge resset) begin
      if (!resset) target_ref <= 1'b0;
      else         target_ref <= |w_ref_vec;
   end
`else
   assign target_ref = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_angle_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sim_angle_sched
// Description : Directed self-checking bench for sim_angle_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_angle_sched;
   localparam int NTGT = 4;

   logic        clk = 1'b0;
   logic        resset = 1'b0;
   logic [11:0] bear = 12'd0;
   logic        run = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [11:0] cfg_start = 12'd0;
   logic [11:0] cfg_end = 12'd0;
   logic [3:0]  cfg_mode = 4'd0;
   logic        target_angle, target_ref, rev_pulse;
   logic [1:0]  target_id;

   int n_checks = 0;
   int n_fail   = 0;
   int rev_cnt  = 0;

   sim_angle_sched #(.NTGT(NTGT)) dut (
      .clk(clk), .resset(resset), .bear(bear), .run(run),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_start(cfg_start),
      .cfg_end(cfg_end), .cfg_mode(cfg_mode),
      .target_angle(target_angle), .target_id(target_id),
      .target_ref(target_ref), .rev_pulse(rev_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rev_pulse === 1'b1) rev_cnt = rev_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [11:0] s, input logic [11:0] e,
                     input logic [3:0] m);
      cfg_we = 1'b1; cfg_addr = a; cfg_start = s; cfg_end = e; cfg_mode = m;
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic fake_rev(input int n);
      for (int k = 0; k < n; k++) begin
         bear = 12'hC00; tick(3);
         bear = 12'h000; tick(4);
      end
   endtask

   task automatic test_reset;
      resset = 1'b0; tick(2);
      n_checks++; if (target_angle !== 1'b0) begin n_fail++; $display("FAIL reset_angle got %b want 0", target_angle); end
      n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", target_id); end
      n_checks++; if (target_ref !== 1'b0) begin n_fail++; $display("FAIL reset_ref got %b want 0", target_ref); end
      n_checks++; if (rev_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_rev got %b want 0", rev_pulse); end
      resset = 1'b1; tick(1);
   endtask

   task automatic test_static_sector;
      int   bv[7] = '{0, 100, 101, 150, 199, 200, 300};
      logic ev[7] = '{0, 0, 1, 1, 1, 0, 0};
      logic eref;
      wr(2'd0, 12'd100, 12'd200, 4'b1000);
      run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bear = 12'(bv[i]); tick(10);
         n_checks++;
         if (target_angle !== ev[i]) begin n_fail++; $display("FAIL static bear=%0d angle got %b want %b", bv[i], target_angle, ev[i]); end
         if (bv[i] == 150) begin
`ifdef SIM_SCHED_REF_EN
            eref = 1'b1;
`else
            eref = 1'b0;
`endif
            n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL static_id got %0d want 0", target_id); end
            n_checks++; if (target_ref !== eref) begin n_fail++; $display("FAIL static_ref got %b want %b", target_ref, eref); end
         end
      end
   endtask

   task automatic test_wrap_sector;
      int   bv[8] = '{3999, 4000, 4001, 4095, 0, 49, 50, 100};
      logic ev[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
      wr(2'd0, 12'd100, 12'd200, 4'b0000);
      wr(2'd1, 12'd4000, 12'd50, 4'b1000);
      for (int i = 0; i < 8; i++) begin
         bear = 12'(bv[i]); tick(10);
         n_checks++;
         if (target_angle !== ev[i]) begin n_fail++; $display("FAIL wrap bear=%0d angle got %b want %b", bv[i], target_angle, ev[i]); end
         if (ev[i]) begin
            n_checks++; if (target_id !== 2'd1) begin n_fail++; $display("FAIL wrap_id bear=%0d got %0d want 1", bv[i], target_id); end
         end
      end
      wr(2'd1, 12'd4000, 12'd50, 4'b0000);
   endtask

   task automatic test_moving_fast;
      int   bv[4] = '{102, 103, 201, 202};
      logic ev[4] = '{0, 1, 1, 0};
      int   r0;
      bear = 12'd0; tick(10);
      wr(2'd0, 12'd100, 12'd200, 4'b1011);
      r0 = rev_cnt;
      fake_rev(4);
      n_checks++; if (rev_cnt - r0 != 4) begin n_fail++; $display("FAIL fast_revs got %0d want 4", rev_cnt - r0); end
      for (int i = 0; i < 4; i++) begin
         bear = 12'(bv[i]); tick(10);
         n_checks++;
         if (target_angle !== ev[i]) begin n_fail++; $display("FAIL fast bear=%0d angle got %b want %b", bv[i], target_angle, ev[i]); end
      end
   endtask

   task automatic test_moving_slow;
      int   b8[4]  = '{9, 10, 18, 19};
      logic e8[4]  = '{0, 1, 1, 0};
      int   b88[5] = '{0, 8, 9, 100, 4095};
      logic e88[5] = '{1, 1, 0, 0, 0};
      wr(2'd0, 12'd100, 12'd200, 4'b0000);
      bear = 12'd0; tick(10);
      wr(2'd3, 12'd10, 12'd20, 4'b1110);
      fake_rev(8);
      for (int i = 0; i < 4; i++) begin
         bear = 12'(b8[i]); tick(10);
         n_checks++;
         if (target_angle !== e8[i]) begin n_fail++; $display("FAIL slow8 bear=%0d angle got %b want %b", b8[i], target_angle, e8[i]); end
      end
      fake_rev(80);
      for (int i = 0; i < 5; i++) begin
         bear = 12'(b88[i]); tick(10);
         n_checks++;
         if (target_angle !== e88[i]) begin n_fail++; $display("FAIL slow88 bear=%0d angle got %b want %b", b88[i], target_angle, e88[i]); end
      end
      n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL slow88_id got %0d want 0", target_id); end
      wr(2'd3, 12'd10, 12'd20, 4'b0000);
   endtask

   task automatic test_priority;
      bear = 12'd100; tick(10);
      wr(2'd0, 12'd100, 12'd200, 4'b1000);
      wr(2'd2, 12'd150, 12'd160, 4'b1000);
      bear = 12'd155; tick(10);
      n_checks++; if (target_angle !== 1'b1) begin n_fail++; $display("FAIL prio_angle got %b want 1", target_angle); end
      n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL prio_id got %0d want 0", target_id); end
      wr(2'd0, 12'd100, 12'd200, 4'b0000);
      tick(10);
      n_checks++; if (target_id !== 2'd2) begin n_fail++; $display("FAIL prio_inval_id got %0d want 2", target_id); end
      bear = 12'd170; tick(10);
      n_checks++; if (target_angle !== 1'b0) begin n_fail++; $display("FAIL prio_miss got %b want 0", target_angle); end
      bear = 12'd155; tick(10);
   endtask

   task automatic test_run_stop;
      run = 1'b0; tick(2);
      n_checks++; if (target_angle !== 1'b0) begin n_fail++; $display("FAIL stop_angle got %b want 0", target_angle); end
      n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL stop_id got %0d want 0", target_id); end
      run = 1'b1; tick(10);
      n_checks++; if (target_angle !== 1'b1) begin n_fail++; $display("FAIL resume_angle got %b want 1", target_angle); end
      n_checks++; if (target_id !== 2'd2) begin n_fail++; $display("FAIL resume_id got %0d want 2", target_id); end
   endtask

   task automatic test_reset_midscan;
      resset = 1'b0; #1;
      n_checks++; if (target_angle !== 1'b0) begin n_fail++; $display("FAIL rst_mid_angle got %b want 0", target_angle); end
      n_checks++; if (target_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_id got %0d want 0", target_id); end
      tick(2);
      resset = 1'b1; run = 1'b1; bear = 12'd155; tick(10);
      n_checks++; if (target_angle !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_lost got %b want 0", target_angle); end
      wr(2'd2, 12'd150, 12'd160, 4'b1000);
      tick(10);
      n_checks++; if (target_angle !== 1'b1) begin n_fail++; $display("FAIL rst_rewrite got %b want 1", target_angle); end
   endtask

   initial begin
      test_reset();
      test_static_sector();
      test_wrap_sector();
      test_moving_fast();
      test_moving_slow();
      test_priority();
      test_run_stop();
      test_reset_midscan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
